// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the FSM state encoding, Wishbone cycle-type codes and the watchdog default.
package wb_arb_pkg;

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int TMO_CYC_DEF = 256;

    function automatic logic [1:0] gnt_of(input arb_state_e st);
        logic [1:0] g;
        case (st)
            ST_OWN0: g = 2'b01;
            ST_OWN1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wb_arb_wdog.sv
// Stall watchdog: counts strobed cycles without an acknowledge and
// flags a one-cycle expiry once the configured limit is reached.
module wb_arb_wdog #(
    parameter int TMO_CYC = wb_arb_pkg::TMO_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_stb,
    input  logic i_ack,
    input  logic i_clr,
    output logic o_expire
);
    localparam logic [15:0] LIMIT = 16'(TMO_CYC - 1);

    logic [15:0] r_cnt;
    logic        r_expire;

    // Stall counter and registered expiry pulse; an ack on the limit cycle wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= 16'd0;
            r_expire <= 1'b0;
        end else if (i_clr || i_ack || !i_stb) begin
            r_cnt    <= 16'd0;
            r_expire <= 1'b0;
        end else if (r_cnt == LIMIT) begin
            r_cnt    <= 16'd0;
            r_expire <= 1'b1;
        end else begin
            r_cnt    <= r_cnt + 16'd1;
            r_expire <= 1'b0;
        end
    end

    assign o_expire = r_expire;

endmodule

// File: rtl/wb_arb_2m.sv
// Two-master round-robin Wishbone arbiter in front of a single slave port,
// with a per-transfer stall watchdog that returns err to the owning master.
module wb_arb_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = wb_arb_pkg::TMO_CYC_DEF
) (
    input  logic            wb_clk_i,
    input  logic            RESETN,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [2:0]      m0_cti_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [2:0]      m1_cti_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_addr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [2:0]      s_cti_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    output logic [1:0]      gnt_o
);
    import wb_arb_pkg::*;

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_last_m1;
    logic       w_last_m1_nxt;
    logic       w_expire;
    logic       w_clr;

    // State and round-robin pointer; pointer resets as "m1 served last" so m0 wins first.
    always_ff @(posedge wb_clk_i or negedge RESETN) begin
        if (!RESETN) begin
            r_state   <= ST_IDLE;
            r_last_m1 <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_last_m1 <= w_last_m1_nxt;
        end
    end

    // Next-state: grant from IDLE, hand over directly on release, no preemption.
    always_comb begin
        w_state_nxt   = r_state;
        w_last_m1_nxt = r_last_m1;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last_m1 ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = ST_OWN0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = ST_OWN1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    w_last_m1_nxt = 1'b0;
                    w_state_nxt   = m1_cyc_i ? ST_OWN1 : ST_IDLE;
                end else begin
                    w_state_nxt = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    w_last_m1_nxt = 1'b1;
                    w_state_nxt   = m0_cyc_i ? ST_OWN0 : ST_IDLE;
                end else begin
                    w_state_nxt = ST_OWN1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_clr = (w_state_nxt != r_state);

    wb_arb_wdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .i_clk    (wb_clk_i),
        .i_rst_n  (RESETN),
        .i_stb    (s_stb_o),
        .i_ack    (s_ack_i),
        .i_clr    (w_clr),
        .o_expire (w_expire)
    );

    // Output mux; err is masked by ack so the two can never coincide.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = {AW{1'b0}};
        s_dat_o  = {DW{1'b0}};
        s_sel_o  = {(DW/8){1'b0}};
        s_cti_o  = 3'b000;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (r_state)
            ST_OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~w_expire;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_cti_o  = m0_cti_i;
                m0_ack_o = s_ack_i;
                m0_err_o = w_expire & ~s_ack_i;
            end
            ST_OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~w_expire;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_cti_o  = m1_cti_i;
                m1_ack_o = s_ack_i;
                m1_err_o = w_expire & ~s_ack_i;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt_o    = gnt_of(r_state);

endmodule

// File: tb/tb_wb_arb_2m.sv
// Self-checking bench for wb_arb_2m: zero-wait memory slave model,
// scoreboard queues for read data and per-cycle grant/ack expectations.
module tb_wb_arb_2m;
    import wb_arb_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        RESETN;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic [2:0]  m0_cti_i;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic [2:0]  m1_cti_i;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_addr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic [1:0]  gnt_o;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_q[$];
    logic [3:0]  gnt_q[$];

    logic        slave_en;
    logic [31:0] mem [0:63];
    bit          mem_v [0:63];

    int m0_acks = 0;
    int m1_acks = 0;
    int both_hi = 0;

    wb_arb_2m #(.AW(32), .DW(32), .TMO_CYC(16)) dut (
        .wb_clk_i (wb_clk_i),  .RESETN   (RESETN),
        .m0_cyc_i (m0_cyc_i),  .m0_stb_i (m0_stb_i),  .m0_we_i  (m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_dat_i (m0_dat_i),  .m0_sel_i (m0_sel_i),
        .m0_cti_i (m0_cti_i),  .m0_dat_o (m0_dat_o),  .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i),  .m1_stb_i (m1_stb_i),  .m1_we_i  (m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_dat_i (m1_dat_i),  .m1_sel_i (m1_sel_i),
        .m1_cti_i (m1_cti_i),  .m1_dat_o (m1_dat_o),  .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),   .s_stb_o  (s_stb_o),   .s_we_o   (s_we_o),
        .s_addr_o (s_addr_o),  .s_dat_o  (s_dat_o),   .s_sel_o  (s_sel_o),
        .s_cti_o  (s_cti_o),   .s_dat_i  (s_dat_i),   .s_ack_i  (s_ack_i),
        .gnt_o    (gnt_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [31:0] pat(input int idx);
        return 32'hA500_0000 + 32'(idx);
    endfunction

    // Zero-wait slave: unwritten words read back as a fixed address pattern.
    always_comb begin
        s_ack_i = slave_en & s_cyc_o & s_stb_o;
        s_dat_i = mem_v[s_addr_o[7:2]] ? mem[s_addr_o[7:2]] : pat(int'(s_addr_o[7:2]));
    end

    always @(posedge wb_clk_i) begin
        if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) begin
            mem[s_addr_o[7:2]]   <= s_dat_o;
            mem_v[s_addr_o[7:2]] <= 1'b1;
        end
    end

    always @(negedge wb_clk_i) begin
        if (m0_ack_o === 1'b1) m0_acks <= m0_acks + 1;
        if (m1_ack_o === 1'b1) m1_acks <= m1_acks + 1;
        if ((m0_ack_o && m0_err_o) || (m1_ack_o && m1_err_o)) both_hi <= both_hi + 1;
    end

    task automatic set_m0(input logic cyc, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [2:0] cti);
        m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we;
        m0_addr_i = adr; m0_dat_i = dat; m0_sel_i = 4'hF; m0_cti_i = cti;
    endtask

    task automatic set_m1(input logic cyc, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [2:0] cti);
        m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we;
        m1_addr_i = adr; m1_dat_i = dat; m1_sel_i = 4'hF; m1_cti_i = cti;
    endtask

    task automatic wait_ack(input int m, input int budget, output logic got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge wb_clk_i);
            if (((m == 0) ? m0_ack_o : m1_ack_o) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        set_m0(1'b0, 1'b0, 32'd0, 32'd0, CTI_CLASSIC);
        set_m1(1'b0, 1'b0, 32'd0, 32'd0, CTI_CLASSIC);
        slave_en = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 8'h00) begin
            $display("FAIL reset_ctl: got %b expected 00000000",
                     {gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        end else n_pass++;
        n_total++;
        if ({s_addr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o} !== 72'd0) begin
            $display("FAIL reset_bus: addr %h dat %h sel %h cti %h expected all 0",
                     s_addr_o, s_dat_o, s_sel_o, s_cti_o);
        end else n_pass++;
        RESETN = 1'b1;
    endtask

    task automatic test_single();
        logic got;
        int   m1_snap;
        m1_snap = m1_acks;
        set_m0(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, CTI_CLASSIC);
        @(negedge wb_clk_i);
        n_total++;
        if ({gnt_o, s_stb_o} !== 3'b000) begin
            $display("FAIL single_latency: gnt %b stb %b expected 00 0", gnt_o, s_stb_o);
        end else n_pass++;
        @(negedge wb_clk_i);
        n_total++;
        if ({gnt_o, m0_ack_o, s_addr_o, s_dat_o} !== {2'b01, 1'b1, 32'h40, 32'hDEADBEEF}) begin
            $display("FAIL single_write: gnt %b ack %b addr %h dat %h expected 01 1 40 deadbeef",
                     gnt_o, m0_ack_o, s_addr_o, s_dat_o);
        end else n_pass++;
        @(posedge wb_clk_i); #1;
        set_m0(1'b0, 1'b0, 32'h40, 32'd0, CTI_CLASSIC);
        @(posedge wb_clk_i); #1;
        set_m0(1'b1, 1'b0, 32'h40, 32'd0, CTI_CLASSIC);
        exp_q.push_back(32'hDEADBEEF);
        wait_ack(0, 10, got);
        n_total++;
        if (!got) begin
            $display("FAIL single_read_timeout: no m0 ack within 10 cycles");
            void'(exp_q.pop_front());
        end else if (m0_dat_o !== exp_q[0]) begin
            $display("FAIL single_read: got %h expected %h", m0_dat_o, exp_q.pop_front());
        end else begin
            void'(exp_q.pop_front());
            n_pass++;
        end
        @(posedge wb_clk_i); #1;
        set_m0(1'b0, 1'b0, 32'd0, 32'd0, CTI_CLASSIC);
        @(posedge wb_clk_i); #1;
        n_total++;
        if (m1_acks != m1_snap) begin
            $display("FAIL single_m1_ack: got %0d m1 acks expected 0", m1_acks - m1_snap);
        end else n_pass++;
    endtask

    task automatic test_contention();
        logic [1:0] req [0:11];
        logic [1:0] eg  [0:11];
        logic [3:0] e;
        req = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
        eg  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        do_reset();
        RESETN = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin
                @(posedge wb_clk_i); #1;
            end
            set_m0(req[c][0], 1'b0, 32'h10, 32'd0, CTI_CLASSIC);
            set_m1(req[c][1], 1'b0, 32'h14, 32'd0, CTI_CLASSIC);
            gnt_q.push_back({eg[c], eg[c][0] & req[c][0], eg[c][1] & req[c][1]});
            if (c == 3) exp_q.push_back(pat(5));
            @(negedge wb_clk_i);
            e = gnt_q.pop_front();
            n_total++;
            if ({gnt_o, m0_ack_o, m1_ack_o} !== e) begin
                $display("FAIL contention_c%0d: gnt/ack0/ack1 got %b expected %b",
                         c, {gnt_o, m0_ack_o, m1_ack_o}, e);
            end else n_pass++;
            if (c == 3) begin
                n_total++;
                if (m1_dat_o !== exp_q[0]) begin
                    $display("FAIL contention_m1_data: got %h expected %h", m1_dat_o, exp_q[0]);
                end else n_pass++;
                void'(exp_q.pop_front());
            end
        end
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_burst();
        int   beat;
        int   next_push;
        int   leak;
        logic got;
        beat = 0; next_push = 1; leak = 0;
        set_m1(1'b1, 1'b0, 32'h20, 32'd0, CTI_INCR);
        exp_q.push_back(pat(8));
        for (int c = 0; c < 30 && beat < 8; c++) begin
            @(negedge wb_clk_i);
            if (m0_ack_o !== 1'b0) leak++;
            if (m1_ack_o === 1'b1) begin
                n_total++;
                if (m1_dat_o !== exp_q[0]) begin
                    $display("FAIL burst_beat%0d: got %h expected %h", beat, m1_dat_o, exp_q[0]);
                end else n_pass++;
                void'(exp_q.pop_front());
                beat++;
            end
            @(posedge wb_clk_i); #1;
            if (beat == 2 && !m0_cyc_i) set_m0(1'b1, 1'b0, 32'h08, 32'd0, CTI_CLASSIC);
            if (beat < 8) begin
                set_m1(1'b1, 1'b0, 32'h20 + 32'(4 * beat), 32'd0, (beat == 7) ? CTI_EOB : CTI_INCR);
                if (beat == next_push) begin
                    exp_q.push_back(pat(8 + beat));
                    next_push++;
                end
            end else begin
                set_m1(1'b0, 1'b0, 32'd0, 32'd0, CTI_CLASSIC);
            end
        end
        n_total++;
        if (beat != 8) begin
            $display("FAIL burst_timeout: got %0d beats expected 8", beat);
            exp_q.delete();
        end else n_pass++;
        @(negedge wb_clk_i);
        n_total++;
        if (leak != 0 || m0_ack_o !== 1'b0 || gnt_o !== 2'b10) begin
            $display("FAIL burst_no_preempt: leaks %0d ack0 %b gnt %b expected 0 0 10",
                     leak, m0_ack_o, gnt_o);
        end else n_pass++;
        exp_q.push_back(pat(2));
        wait_ack(0, 4, got);
        n_total++;
        if (!got || gnt_o !== 2'b01 || m0_dat_o !== exp_q[0]) begin
            $display("FAIL burst_m0_after: ack %b gnt %b dat %h expected 1 01 %h",
                     got, gnt_o, m0_dat_o, exp_q[0]);
        end else n_pass++;
        void'(exp_q.pop_front());
        @(posedge wb_clk_i); #1;
        set_m0(1'b0, 1'b0, 32'd0, 32'd0, CTI_CLASSIC);
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_watchdog();
        int         first_err, err_cnt;
        logic       stb17, stb18, ack33, err34;
        logic [1:0] gnt17;
        first_err = 0; err_cnt = 0;
        stb17 = 1'b1; stb18 = 1'b0; ack33 = 1'b0; err34 = 1'b1; gnt17 = 2'b00;
        slave_en = 1'b0;
        set_m0(1'b1, 1'b1, 32'h44, 32'hCAFE0001, CTI_CLASSIC);
        for (int k = 1; k <= 34; k++) begin
            @(posedge wb_clk_i); #1;
            if (k == 33) slave_en = 1'b1;
            if (k == 34) set_m0(1'b0, 1'b0, 32'd0, 32'd0, CTI_CLASSIC);
            @(negedge wb_clk_i);
            if (k <= 32 && m0_err_o === 1'b1) begin
                err_cnt++;
                if (first_err == 0) first_err = k;
            end
            if (k == 17) begin stb17 = s_stb_o; gnt17 = gnt_o; end
            if (k == 18) stb18 = s_stb_o;
            if (k == 33) ack33 = m0_ack_o;
            if (k == 34) err34 = m0_err_o;
        end
        n_total++;
        if (first_err != 17 || err_cnt != 1) begin
            $display("FAIL wdog_err: first at %0d count %0d expected 17 1", first_err, err_cnt);
        end else n_pass++;
        n_total++;
        if (stb17 !== 1'b0 || gnt17 !== 2'b01) begin
            $display("FAIL wdog_stb_gnt: stb %b gnt %b expected 0 01", stb17, gnt17);
        end else n_pass++;
        n_total++;
        if (stb18 !== 1'b1) begin
            $display("FAIL wdog_restart: stb %b expected 1", stb18);
        end else n_pass++;
        n_total++;
        if (ack33 !== 1'b1 || err34 !== 1'b0) begin
            $display("FAIL wdog_ack_wins: ack %b err %b expected 1 0", ack33, err34);
        end else n_pass++;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic test_reset_mid_burst();
        int snap;
        set_m0(1'b1, 1'b0, 32'h20, 32'h12345678, CTI_INCR);
        m0_dat_i = 32'h12345678;
        for (int c = 1; c <= 3; c++) begin
            @(posedge wb_clk_i); #1;
            set_m0(1'b1, 1'b0, 32'h20 + 32'(4 * (c - 1)), 32'h12345678, CTI_INCR);
        end
        #2;
        snap = m0_acks;
        RESETN = 1'b0;
        #1;
        n_total++;
        if ({gnt_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o} !== 77'd0) begin
            $display("FAIL rst_mid_now: gnt %b cyc %b stb %b ack %b addr %h dat %h sel %h expected 0",
                     gnt_o, s_cyc_o, s_stb_o, m0_ack_o, s_addr_o, s_dat_o, s_sel_o);
        end else n_pass++;
        @(posedge wb_clk_i); #1;
        n_total++;
        if ({gnt_o, s_stb_o, m0_ack_o} !== 4'b0000) begin
            $display("FAIL rst_mid_hold: gnt %b stb %b ack %b expected 00 0 0", gnt_o, s_stb_o, m0_ack_o);
        end else n_pass++;
        @(negedge wb_clk_i);
        RESETN = 1'b1;
        #1;
        n_total++;
        if (gnt_o !== 2'b00 || s_stb_o !== 1'b0 || m0_acks != snap) begin
            $display("FAIL rst_mid_release: gnt %b stb %b acks %0d expected 00 0 0",
                     gnt_o, s_stb_o, m0_acks - snap);
        end else n_pass++;
        @(posedge wb_clk_i); #1;
        set_m0(1'b1, 1'b0, 32'h08, 32'd0, CTI_CLASSIC);
        exp_q.push_back(pat(2));
        @(negedge wb_clk_i);
        n_total++;
        if (gnt_o !== 2'b01 || m0_ack_o !== 1'b1 || m0_dat_o !== exp_q[0]) begin
            $display("FAIL rst_mid_resume: gnt %b ack %b dat %h expected 01 1 %h",
                     gnt_o, m0_ack_o, m0_dat_o, exp_q[0]);
        end else n_pass++;
        void'(exp_q.pop_front());
        @(posedge wb_clk_i); #1;
        set_m0(1'b0, 1'b0, 32'd0, 32'd0, CTI_CLASSIC);
        @(posedge wb_clk_i); #1;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation exceeded 50000 time units");
        $fatal(1);
    end

    initial begin
        RESETN   = 1'b0;
        slave_en = 1'b1;
        set_m0(1'b0, 1'b0, 32'd0, 32'd0, CTI_CLASSIC);
        set_m1(1'b0, 1'b0, 32'd0, 32'd0, CTI_CLASSIC);
        test_reset();
        test_single();
        test_contention();
        test_watchdog();
        test_burst();
        test_reset_mid_burst();
        n_total++;
        if (both_hi != 0) begin
            $display("FAIL ack_err_overlap: got %0d cycles expected 0", both_hi);
        end else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
